multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile_pkg.sv | 22 ++
 rtl/multiport_regfile_reg_scoreboard.sv | 84 ++++++++
 rtl/multiport_regfile.sv | 109 ++++++++++
 tb/tb_multiport_regfile.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multiport_regfile_pkg
// Description : Shared definitions for the multiport register file: default
//               geometry and the word/tag types used around it.
// Revision    : 1.0 - initial release
// ============================================================================
package multiport_regfile_pkg;

    // Default geometry: a classic 32 x 32-bit integer file, 2R/2W.
    localparam int c_NUM_READ  = 2;
    localparam int c_NUM_WRITE = 2;
    localparam int c_XLEN      = 32;
    localparam int c_NUM_REGS  = 32;
    localparam int c_AW        = $clog2(c_NUM_REGS);

    // Data word and register tag at the default geometry.
    typedef logic [c_XLEN-1:0] word_t;
    typedef logic [c_AW-1:0]   tag_t;

endpackage : multiport_regfile_pkg
`default_nettype wire

// File: rtl/multiport_regfile_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Pending-write tracker. One busy bit per architectural register
//               (none for register 0). Lookups return the busy state as it
//               will be after the current edge, so a reader sees the same
//               update a same-edge write or issue produces.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import multiport_regfile_pkg::*;
#(
    parameter  int NUM_READ  = c_NUM_READ,
    parameter  int NUM_WRITE = c_NUM_WRITE,
    parameter  int NUM_REGS  = c_NUM_REGS,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          issue_valid,
    input  logic [AW-1:0]                 issue_rd,
    input  logic [NUM_WRITE-1:0]          wb_valid,
    input  logic [NUM_WRITE-1:0][AW-1:0]  wb_addr,
    input  logic                          flush,
    input  logic [NUM_READ-1:0][AW-1:0]   lookup_addr,
    output logic [NUM_READ-1:0]           lookup_busy
);

    logic [NUM_REGS-1:1] r_busy;
    logic [NUM_REGS-1:1] w_busy_next;

    // Next busy state: write-back clears, issue sets (new producer wins over
    // a same-cycle write-back), flush overrides everything. Out-of-range tags
    // never match any entry and so are ignored.
    always_comb begin
        w_busy_next = r_busy;
        for (int p = 0; p < NUM_WRITE; p++) begin
            for (int j = 1; j < NUM_REGS; j++) begin
                if (wb_valid[p] && (wb_addr[p] == AW'(j))) begin
                    w_busy_next[j] = 1'b0;
                end
            end
        end
        for (int j = 1; j < NUM_REGS; j++) begin
            if (issue_valid && (issue_rd == AW'(j))) begin
                w_busy_next[j] = 1'b1;
            end
        end
        if (flush) begin
            w_busy_next = '0;
        end
    end

    // Busy-bit state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_lookup
            logic w_hit;

            // Post-update busy view for this lookup; register 0 and
            // out-of-range tags are never busy.
            always_comb begin
                w_hit = 1'b0;
                for (int j = 1; j < NUM_REGS; j++) begin
                    if (lookup_addr[gi] == AW'(j)) begin
                        w_hit = w_busy_next[j];
                    end
                end
            end

            assign lookup_busy[gi] = w_hit;
        end
    endgenerate

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module      : multiport_regfile
// Description : Parameterised multi-read / multi-write register file with
//               registered reads, write-before-read forwarding, a read-hold
//               stall and a per-register pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter  int NUM_READ  = c_NUM_READ,
    parameter  int NUM_WRITE = c_NUM_WRITE,
    parameter  int XLEN      = c_XLEN,
    parameter  int NUM_REGS  = c_NUM_REGS,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           stall,
    input  logic [NUM_READ-1:0][AW-1:0]    rd_addr,
    output logic [NUM_READ-1:0][XLEN-1:0]  rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic [NUM_WRITE-1:0]           wr_valid,
    input  logic [NUM_WRITE-1:0][AW-1:0]   wr_addr,
    input  logic [NUM_WRITE-1:0][XLEN-1:0] wr_data,
    input  logic                           issue_valid,
    input  logic [AW-1:0]                  issue_rd,
    input  logic                           flush
);

    // Storage has no entry for register 0; it is synthesised as constant 0.
    logic [NUM_REGS-1:1][XLEN-1:0] r_regs;
    logic [NUM_REGS-1:1][XLEN-1:0] w_regs_next;
    logic [NUM_READ-1:0][XLEN-1:0] w_rd_data_next;
    logic [NUM_READ-1:0]           w_rd_busy_next;

    // Next register contents: ports are scanned in ascending order so the
    // highest-index port targeting a register wins. Writes to register 0 or
    // out-of-range tags match no entry and are dropped.
    always_comb begin
        w_regs_next = r_regs;
        for (int p = 0; p < NUM_WRITE; p++) begin
            for (int j = 1; j < NUM_REGS; j++) begin
                if (wr_valid[p] && (wr_addr[p] == AW'(j))) begin
                    w_regs_next[j] = wr_data[p];
                end
            end
        end
    end

    // Register array update; writes proceed regardless of stall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_regs <= '0;
        end else begin
            r_regs <= w_regs_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd_port
            logic [XLEN-1:0] w_mux;

            // Read from the post-write view so a same-edge write is
            // forwarded; register 0 and out-of-range tags return 0.
            always_comb begin
                w_mux = '0;
                for (int j = 1; j < NUM_REGS; j++) begin
                    if (rd_addr[gi] == AW'(j)) begin
                        w_mux = w_regs_next[j];
                    end
                end
            end

            assign w_rd_data_next[gi] = w_mux;
        end
    endgenerate

    reg_scoreboard #(
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE),
        .NUM_REGS  (NUM_REGS)
    ) u_scoreboard (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wr_valid),
        .wb_addr     (wr_addr),
        .flush       (flush),
        .lookup_addr (rd_addr),
        .lookup_busy (w_rd_busy_next)
    );

    // Registered read outputs; held while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else if (!stall) begin
            rd_data <= w_rd_data_next;
            rd_busy <= w_rd_busy_next;
        end
    end

endmodule : multiport_regfile
`default_nettype wire

// File: tb/tb_multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiport_regfile
// Description : Directed self-checking bench for multiport_regfile at the
//               default 2R/2W, 32 x 32-bit geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiport_regfile;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int XL = 32;
    localparam int NG = 32;
    localparam int AW = 5;

    logic                  clock;
    logic                  reset_n;
    logic                  stall;
    logic [NR-1:0][AW-1:0] rd_addr;
    logic [NR-1:0][XL-1:0] rd_data;
    logic [NR-1:0]         rd_busy;
    logic [NW-1:0]         wr_valid;
    logic [NW-1:0][AW-1:0] wr_addr;
    logic [NW-1:0][XL-1:0] wr_data;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  flush;

    int n_cmp;
    int n_err;

    multiport_regfile #(
        .NUM_READ  (NR),
        .NUM_WRITE (NW),
        .XLEN      (XL),
        .NUM_REGS  (NG)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (stall),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        stall       = 1'b0;
        wr_valid    = '0;
        wr_addr     = '0;
        wr_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
    endtask

    // Advance one active edge and settle outputs.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        rd_addr = '0;
        tick();
        n_cmp++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: data=%h busy=%b required data=0 busy=0", rd_data, rd_busy);
        end
        #3 reset_n = 1'b1;
        rd_addr[0] = 5'd5;
        tick();
        n_cmp++;
        if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_read_x5: data=%h busy=%b required data=0 busy=0", rd_data[0], rd_busy[0]);
        end
    endtask

    task automatic test_forwarding();
        idle();
        wr_valid[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'hDEADBEEF;
        rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
        tick();
        n_cmp++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_data[1] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL fwd_x3: p0=%h p1=%h required DEADBEEF", rd_data[0], rd_data[1]);
        end
        idle();
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd3;
        tick();
        n_cmp++;
        if (rd_data[1] !== 32'hDEADBEEF || rd_data[0] !== 32'h0) begin
            n_err++;
            $display("FAIL stored_x3: p1=%h p0=%h required DEADBEEF/0", rd_data[1], rd_data[0]);
        end
    endtask

    task automatic test_write_priority();
        idle();
        wr_valid = 2'b11;
        wr_addr[0] = 5'd7; wr_data[0] = 32'h11;
        wr_addr[1] = 5'd7; wr_data[1] = 32'h22;
        rd_addr[0] = 5'd7;
        tick();
        n_cmp++;
        if (rd_data[0] !== 32'h22) begin
            n_err++;
            $display("FAIL prio_x7_fwd: got %h required 22", rd_data[0]);
        end
        idle();
        wr_valid = 2'b11;
        wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF;
        wr_addr[1] = 5'd0; wr_data[1] = 32'h1234_5678;
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd7;
        tick();
        n_cmp++;
        if (rd_data[0] !== 32'h0) begin
            n_err++;
            $display("FAIL x0_write: got %h required 0", rd_data[0]);
        end
        n_cmp++;
        if (rd_data[1] !== 32'h22) begin
            n_err++;
            $display("FAIL prio_x7_stored: got %h required 22", rd_data[1]);
        end
    endtask

    task automatic test_stall();
        idle();
        wr_valid[1] = 1'b1; wr_addr[1] = 5'd4; wr_data[1] = 32'h44;
        rd_addr[0] = 5'd4;
        tick();
        n_cmp++;
        if (rd_data[0] !== 32'h44) begin
            n_err++;
            $display("FAIL stall_pre: got %h required 44", rd_data[0]);
        end
        idle();
        stall = 1'b1;
        wr_valid[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h55;
        for (int c = 0; c < 3; c++) begin
            tick();
            wr_valid = '0;
            rd_addr[0] = 5'd3;
            n_cmp++;
            if (rd_data[0] !== 32'h44) begin
                n_err++;
                $display("FAIL stall_hold_%0d: got %h required 44", c, rd_data[0]);
            end
        end
        stall = 1'b0;
        rd_addr[0] = 5'd4;
        tick();
        n_cmp++;
        if (rd_data[0] !== 32'h55) begin
            n_err++;
            $display("FAIL stall_release: got %h required 55", rd_data[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        rd_addr[0] = 5'd9; rd_addr[1] = 5'd0;
        tick();
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL issue_x9: busy=%b required 1", rd_busy[0]);
        end
        wr_valid[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
        tick();
        n_cmp++;
        if (rd_busy[0] !== 1'b1 || rd_data[0] !== 32'h99) begin
            n_err++;
            $display("FAIL issue_wb_x9: busy=%b data=%h required 1/99", rd_busy[0], rd_data[0]);
        end
        idle();
        wr_valid[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h9A;
        tick();
        n_cmp++;
        if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'h9A) begin
            n_err++;
            $display("FAIL wb_x9: busy=%b data=%h required 0/9A", rd_busy[0], rd_data[0]);
        end
        idle();
        issue_valid = 1'b1; issue_rd = 5'd5;
        wr_valid[0] = 1'b1; wr_addr[0] = 5'd12; wr_data[0] = 32'hC0DE;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd12;
        tick();
        n_cmp++;
        if (rd_busy !== 2'b01 || rd_data[1] !== 32'hC0DE) begin
            n_err++;
            $display("FAIL issue_x5_wb_x12: busy=%b data1=%h required 01/C0DE", rd_busy, rd_data[1]);
        end
        idle();
        flush = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd2;
        rd_addr[0] = 5'd2; rd_addr[1] = 5'd5;
        tick();
        n_cmp++;
        if (rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL flush: busy=%b required 00", rd_busy);
        end
        idle();
        issue_valid = 1'b1; issue_rd = 5'd0;
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd5;
        tick();
        n_cmp++;
        if (rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL issue_x0: busy=%b required 00", rd_busy);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int k = 0; k < 4; k++) begin
            wr_valid[k % 2] = 1'b1;
            wr_valid[(k + 1) % 2] = 1'b0;
            wr_addr[k % 2] = AW'(10 + k);
            wr_data[k % 2] = 32'hA000_0000 + 32'(k);
            rd_addr[0] = AW'(10 + k);
            rd_addr[1] = (k == 0) ? 5'd0 : AW'(9 + k);
            tick();
            n_cmp++;
            if (rd_data[0] !== 32'hA000_0000 + 32'(k) ||
                rd_data[1] !== ((k == 0) ? 32'h0 : 32'hA000_0000 + 32'(k - 1))) begin
                n_err++;
                $display("FAIL b2b_%0d: p0=%h p1=%h", k, rd_data[0], rd_data[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd6;
        wr_valid[0] = 1'b1; wr_addr[0] = 5'd6; wr_data[0] = 32'hA5;
        rd_addr[0] = 5'd6; rd_addr[1] = 5'd6;
        tick();
        n_cmp++;
        if (rd_data[0] !== 32'hA5 || rd_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_x6: data=%h busy=%b required A5/1", rd_data[0], rd_busy[0]);
        end
        idle();
        wr_valid[0] = 1'b1; wr_addr[0] = 5'd6; wr_data[0] = 32'hBB;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            n_err++;
            $display("FAIL async_reset: data=%h busy=%b required all 0", rd_data, rd_busy);
        end
        tick();
        #3 reset_n = 1'b1;
        wr_valid = '0;
        tick();
        n_cmp++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            n_err++;
            $display("FAIL post_reset_x6: data=%h busy=%b required all 0", rd_data, rd_busy);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_forwarding();
        test_write_priority();
        test_stall();
        test_scoreboard();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_multiport_regfile
`default_nettype wire
